// File: rtl/key_conditioner.sv
// Button front end: per-key 2-FF sync, debounce FSM, press/release/long strobes.
// Optional auto-repeat strobe on key_rep is built only when KEY_AUTOREPEAT_EN is defined.

module key_conditioner_lane #(
    parameter int DEB_MS  = 20,
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic clk_1khz,
    input  logic clr_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_rep
);

    localparam int DW = $clog2(DEB_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_MS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DEB_DN = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_LONG   = 3'd3;
    localparam logic [2:0] ST_DEB_UP = 3'd4;

    if (DEB_MS < 2 || REP_MS < 2 || LONG_MS < 1) begin : g_bad_params
        $error("key_conditioner: DEB_MS and REP_MS must be >= 2, LONG_MS >= 1");
    end

    logic [1:0]    sync_q;
    logic          s;
    logic [2:0]    state_q, state_d;
    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          org_long_q, org_long_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REP_MS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REP_MS - 1);
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_q, rep_d;
`endif

    assign s        = sync_q[1];
    // hold timer saturates one short of LONG_MS so a late bounce-back still fires long
    assign hold_inc = (hold_q < HOLD_LAST) ? hold_q + HW'(1) : hold_q;

    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        hold_d     = hold_q;
        org_long_d = org_long_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rep_cnt_d  = rep_cnt_q;
        rep_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (s) begin
                    state_d = ST_DEB_DN;
                    deb_d   = DW'(1);
                end
            end
            ST_DEB_DN: begin
                if (!s) begin
                    state_d = ST_IDLE;
                    deb_d   = '0;
                end else if (deb_q >= DEB_LAST) begin
                    state_d = ST_HELD;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    hold_d  = '0;
                    deb_d   = '0;
                end else begin
                    deb_d = deb_q + DW'(1);
                end
            end
            ST_HELD: begin
                if (!s) begin
                    state_d    = ST_DEB_UP;
                    org_long_d = 1'b0;
                    deb_d      = DW'(1);
                    hold_d     = hold_inc;
                end else if (hold_q >= HOLD_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                    rep_d     = 1'b1;
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_d = hold_inc;
                end
            end
            ST_LONG: begin
                if (!s) begin
                    state_d    = ST_DEB_UP;
                    org_long_d = 1'b1;
                    deb_d      = DW'(1);
                end
`ifdef KEY_AUTOREPEAT_EN
                else if (rep_cnt_q >= REP_LAST) begin
                    rep_d     = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + RW'(1);
                end
`endif
            end
            ST_DEB_UP: begin
                if (s) begin
                    state_d = org_long_q ? ST_LONG : ST_HELD;
                    deb_d   = '0;
                    if (!org_long_q) hold_d = hold_inc;
                end else if (deb_q >= DEB_LAST) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                    deb_d     = '0;
                    hold_d    = '0;
`ifdef KEY_AUTOREPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    deb_d = deb_q + DW'(1);
                    if (!org_long_q) hold_d = hold_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                deb_d   = '0;
                hold_d  = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_1khz or negedge clr_n) begin
        if (!clr_n) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            deb_q      <= '0;
            hold_q     <= '0;
            org_long_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], key_raw ^ ACT_LOW};
            state_q    <= state_d;
            deb_q      <= deb_d;
            hold_q     <= hold_d;
            org_long_q <= org_long_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk_1khz or negedge clr_n) begin
        if (!clr_n) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end
    assign key_rep = rep_q;
`else
    assign key_rep = 1'b0;
`endif

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

module key_conditioner #(
    parameter int                N_KEYS  = 3,
    parameter int                DEB_MS  = 20,
    parameter int                LONG_MS = 1000,
    parameter int                REP_MS  = 200,
    parameter logic [N_KEYS-1:0] ACT_LOW = N_KEYS'(3'b100)
) (
    input  logic              clk_1khz,
    input  logic              clr_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_rep
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
        key_conditioner_lane #(
            .DEB_MS (DEB_MS),
            .LONG_MS(LONG_MS),
            .REP_MS (REP_MS),
            .ACT_LOW(ACT_LOW[i])
        ) u_lane (
            .clk_1khz   (clk_1khz),
            .clr_n      (clr_n),
            .key_raw    (key_raw[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i]),
            .key_rep    (key_rep[i])
        );
    end

endmodule
